// File: rtl/led_blink_arbiter_if.sv
// Bundle of request/blink-count inputs and LED/grant outputs for led_blink_arbiter.
// The arbiter uses the slave modport; the status sources use the master modport.
interface led_blink_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] blinks;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic                   led;

  modport master (
    output req,
    output blinks,
    input  grant,
    input  done,
    input  busy,
    input  led
  );

  modport slave (
    input  req,
    input  blinks,
    output grant,
    output done,
    output busy,
    output led
  );
endinterface

// File: rtl/led_blink_arbiter.sv
// Shares one status LED among N_REQ requesters: arbitrate, blink ON/OFF bursts, then a quiet gap.
// Define LED_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module led_blink_arbiter #(
  parameter int N_REQ   = 4,
  parameter int T_ON    = 5,
  parameter int T_OFF   = 4,
  parameter int T_GAP   = 8,
  parameter int CNT_W   = 4,
  parameter int TIMER_W = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  led_blink_arbiter_if.slave    bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(T_ON - 1);
  localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(T_OFF - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(T_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF,
    ST_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               busy_q, busy_d;
  logic               led_q, led_d;

  logic [CNT_W-1:0]   blinks_arr [N_REQ];
  logic [N_REQ-1:0]   owner_onehot_d;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign blinks_arr[gi]     = bus.blinks[gi*CNT_W +: CNT_W];
      assign owner_onehot_d[gi] = (owner_d == IDX_W'(gi));
    end
  endgenerate

`ifdef LED_ARB_FIXED_PRIO_EN
  // Scan downwards so the lowest requesting index is the last to overwrite.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    int cand;
    cand      = 0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = (int'(rr_ptr_q) + off) % N_REQ;
      if (!win_valid && bus.req[cand]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_IDLE && win_valid) begin
      rr_ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    remaining_d = remaining_q;
    owner_d     = owner_q;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (win_valid) begin
          state_d     = ST_ON;
          owner_d     = win_idx;
          // A zero count still yields one blink.
          remaining_d = (blinks_arr[win_idx] == '0) ? CNT_W'(1) : blinks_arr[win_idx];
        end
      end
      ST_ON: begin
        if (timer_q == ON_LAST) begin
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        if (timer_q == OFF_LAST) begin
          remaining_d = remaining_q - 1'b1;
          state_d     = (remaining_q > CNT_W'(1)) ? ST_ON : ST_GAP;
        end
      end
      ST_GAP: begin
        if (timer_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end
  end

  // Outputs are decoded from the next state so they line up with it once registered.
  always_comb begin
    grant_d = '0;
    done_d  = '0;
    busy_d  = (state_d != ST_IDLE);
    led_d   = (state_d == ST_ON);
    if (state_d == ST_ON || state_d == ST_OFF) begin
      grant_d = owner_onehot_d;
    end
    if (state_q == ST_OFF && state_d == ST_GAP) begin
      done_d = owner_onehot_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      remaining_q <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      led_q       <= led_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.led   = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed self-checking bench for led_blink_arbiter (N_REQ=4, T_ON=5, T_OFF=4, T_GAP=8).
module tb_led_blink_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  led_blink_arbiter_if #(.N_REQ(4), .CNT_W(4)) bus ();

  led_blink_arbiter #(
    .N_REQ(4), .T_ON(5), .T_OFF(4), .T_GAP(8), .CNT_W(4), .TIMER_W(8)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    bus.req    = '0;
    bus.blinks = 16'h1111;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset held two cycles with every requester active; test_round_robin continues from here.
  task automatic test_reset();
    @(negedge clk);
    rst        = 1'b1;
    bus.req    = 4'b1111;
    bus.blinks = 16'h1111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus.grant !== 4'b0000 || bus.done !== 4'b0000 || bus.busy !== 1'b0 || bus.led !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: grant=%b done=%b busy=%b led=%b required 0000 0000 0 0",
                 c, bus.grant, bus.done, bus.busy, bus.led);
      end
      $display("reset cycle %0d: grant=%b done=%b busy=%b led=%b", c, bus.grant, bus.done, bus.busy, bus.led);
    end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] prev_g;
    logic [3:0] exp_g;
    int         n_grants;
    prev_g   = 4'b0000;
    n_grants = 0;
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      if (bus.grant !== 4'b0000 && prev_g === 4'b0000) begin
        exp_g = 4'b0001 << n_grants;
        checks++;
        if (bus.grant !== exp_g || c != 1 + 18 * n_grants) begin
          errors++;
          $display("FAIL rr_grant #%0d: grant=%b at cycle %0d required %b at cycle %0d",
                   n_grants, bus.grant, c, exp_g, 1 + 18 * n_grants);
        end
        $display("rr grant #%0d: grant=%b cycle %0d", n_grants, bus.grant, c);
        n_grants++;
      end
      if (bus.done !== 4'b0000) begin
        bus.req = bus.req & ~bus.done;
      end
      prev_g = bus.grant;
    end
    checks++;
    if (n_grants != 4) begin
      errors++;
      $display("FAIL rr_grant_count: saw %0d grants required 4", n_grants);
    end
  endtask

  task automatic test_single_burst();
    logic [3:0] exp_g, exp_d;
    logic       exp_l, exp_b;
    do_reset();
    bus.blinks = 16'h0020;
    bus.req    = 4'b0010;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      exp_g = (c <= 18) ? 4'b0010 : 4'b0000;
      exp_l = (c <= 5) || (c >= 10 && c <= 14);
      exp_d = (c == 19) ? 4'b0010 : 4'b0000;
      exp_b = (c <= 26);
      checks++;
      if (bus.grant !== exp_g || bus.led !== exp_l || bus.done !== exp_d || bus.busy !== exp_b) begin
        errors++;
        $display("FAIL burst cycle %0d: grant=%b led=%b done=%b busy=%b required %b %b %b %b",
                 c, bus.grant, bus.led, bus.done, bus.busy, exp_g, exp_l, exp_d, exp_b);
      end
      if (c == 1) bus.req = 4'b0000;
    end
    $display("single burst: 28 cycles checked");
  endtask

  task automatic test_priority();
    logic       seen;
    logic [3:0] exp_g;
    do_reset();
    bus.blinks = 16'h1111;
    bus.req    = 4'b0010;
    seen       = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) bus.req = 4'b0000;
      if (c > 2 && bus.busy === 1'b0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL prio_idle_timeout: busy never returned to 0 within 40 cycles");
    end
    bus.req = 4'b0110;
`ifdef LED_ARB_FIXED_PRIO_EN
    exp_g = 4'b0010;
`else
    exp_g = 4'b0100;
`endif
    @(negedge clk);
    checks++;
    if (bus.grant !== exp_g) begin
      errors++;
      $display("FAIL prio_grant: grant=%b required %b", bus.grant, exp_g);
    end
    $display("priority: req=0110 grant=%b", bus.grant);
    bus.req = 4'b0000;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.blinks = 16'h0300;
    bus.req    = 4'b0100;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.led !== 1'b1 || bus.grant !== 4'b0100) begin
      errors++;
      $display("FAIL midreset_on: led=%b grant=%b required 1 0100", bus.led, bus.grant);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.led !== 1'b0 || bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_abort: led=%b grant=%b busy=%b done=%b required 0 0000 0 0000",
               bus.led, bus.grant, bus.busy, bus.done);
    end
    rst        = 1'b0;
    bus.blinks = 16'h1111;
    bus.req    = 4'b1001;
    @(negedge clk);
    checks++;
    if (bus.grant !== 4'b0001 || bus.done !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_rearb: grant=%b done=%b required 0001 0000", bus.grant, bus.done);
    end
    $display("mid-burst reset: re-arbitrated grant=%b", bus.grant);
    bus.req = 4'b0000;
  endtask

  task automatic test_zero_blinks();
    logic [3:0] exp_g, exp_d;
    logic       exp_l;
    do_reset();
    bus.blinks = 16'h0000;
    bus.req    = 4'b0001;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      exp_g = (c <= 9) ? 4'b0001 : 4'b0000;
      exp_l = (c <= 5);
      exp_d = (c == 10) ? 4'b0001 : 4'b0000;
      checks++;
      if (bus.grant !== exp_g || bus.led !== exp_l || bus.done !== exp_d) begin
        errors++;
        $display("FAIL zero_blinks cycle %0d: grant=%b led=%b done=%b required %b %b %b",
                 c, bus.grant, bus.led, bus.done, exp_g, exp_l, exp_d);
      end
      if (c == 1) bus.req = 4'b0000;
    end
    $display("zero blinks: 18 cycles checked");
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.req    = '0;
    bus.blinks = '0;
    test_reset();
    test_round_robin();
    test_single_burst();
    test_priority();
    test_reset_mid_burst();
    test_zero_blinks();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
